// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: frames bytes off the raw PS/2 lines, decodes make/break/extended
// prefixes, and tracks one target key as a held/released level.
module ps2_key_decoder #(
    parameter logic [7:0]  TARGET_CODE    = 8'h29,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned TO_BITS        = 16
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       make,
    output logic       brake,
    output logic       key_down,
    output logic       frame_err
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    localparam logic [TO_BITS-1:0] TO_MAX = TO_BITS'(TIMEOUT_CYCLES);

    logic               clk_meta_q, clk_s_q, clk_prev_q;
    logic               dat_meta_q, dat_s_q;
    state_t             state_q, state_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               par_q, par_d;
    logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;
    logic               byte_valid_q, byte_valid_d;
    logic               brk_pend_q, brk_pend_d;
    logic               ext_pend_q, ext_pend_d;
    logic [7:0]         key_code_q, key_code_d;
    logic               key_ext_q, key_ext_d;
    logic               make_q, make_d;
    logic               brake_q, brake_d;
    logic               key_down_q, key_down_d;
    logic               frame_err_q, frame_err_d;
    logic               fall;
    logic               timeout;

    assign fall    = clk_prev_q & ~clk_s_q;
    assign timeout = (state_q != S_IDLE) && (to_cnt_q == TO_MAX) && !fall;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        to_cnt_d     = to_cnt_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        brk_pend_d   = brk_pend_q;
        ext_pend_d   = ext_pend_q;
        key_code_d   = key_code_q;
        key_ext_d    = key_ext_q;
        make_d       = 1'b0;
        brake_d      = 1'b0;
        key_down_d   = key_down_q;

        if (fall || state_q == S_IDLE) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + TO_BITS'(1);
        end

        if (timeout) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
        end else if (fall) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!dat_s_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                S_DATA: begin
                    shreg_d   = {dat_s_q, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = dat_s_q;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    if (dat_s_q && (^{shreg_q, par_q})) byte_valid_d = 1'b1;
                    else                                frame_err_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // shreg is stable here: two falls can never occur on consecutive clocks.
        if (byte_valid_q) begin
            if (shreg_q == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else if (shreg_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else begin
                key_code_d = shreg_q;
                key_ext_d  = ext_pend_q;
                brake_d    = brk_pend_q;
                make_d     = ~brk_pend_q;
                brk_pend_d = 1'b0;
                ext_pend_d = 1'b0;
                if (shreg_q == TARGET_CODE && !ext_pend_q) key_down_d = ~brk_pend_q;
            end
        end

        if (timeout) begin
            brk_pend_d = 1'b0;
            ext_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            clk_meta_q   <= 1'b1;
            clk_s_q      <= 1'b1;
            clk_prev_q   <= 1'b1;
            dat_meta_q   <= 1'b1;
            dat_s_q      <= 1'b1;
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            byte_valid_q <= 1'b0;
            brk_pend_q   <= 1'b0;
            ext_pend_q   <= 1'b0;
            key_code_q   <= '0;
            key_ext_q    <= 1'b0;
            make_q       <= 1'b0;
            brake_q      <= 1'b0;
            key_down_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_meta_q   <= ps2_clk;
            clk_s_q      <= clk_meta_q;
            clk_prev_q   <= clk_s_q;
            dat_meta_q   <= ps2_data;
            dat_s_q      <= dat_meta_q;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            to_cnt_q     <= to_cnt_d;
            byte_valid_q <= byte_valid_d;
            brk_pend_q   <= brk_pend_d;
            ext_pend_q   <= ext_pend_d;
            key_code_q   <= key_code_d;
            key_ext_q    <= key_ext_d;
            make_q       <= make_d;
            brake_q      <= brake_d;
            key_down_q   <= key_down_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_ext   = key_ext_q;
    assign make      = make_q;
    assign brake     = brake_q;
    assign key_down  = key_down_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus random frame streams,
// compared against a byte-level event model of the keyboard protocol.
module tb_ps2_key_decoder;

    localparam int HALF = 4;
    localparam int TO   = 50000;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_code;
    logic       key_ext, make, brake, key_down, frame_err;

    ps2_key_decoder #(
        .TARGET_CODE   (8'h29),
        .TIMEOUT_CYCLES(TO),
        .TO_BITS       (16)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_code (key_code),
        .key_ext  (key_ext),
        .make     (make),
        .brake    (brake),
        .key_down (key_down),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_fall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // kind bits: {make, brake, frame_err}
    typedef struct {
        logic [2:0] kind;
        logic [7:0] code;
        logic       ext;
        logic       kd;
        int         lat;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        ev;
    logic       m_brk, m_ext, m_kd, m_kext;
    logic [7:0] m_code;

    task automatic model_clear();
        m_brk = 0; m_ext = 0; m_kd = 0; m_kext = 0; m_code = 8'h00;
        exp_q.delete();
    endtask

    task automatic model_push(input logic [2:0] kind, input int lat);
        ev_t e;
        e.kind = kind; e.code = m_code; e.ext = m_kext; e.kd = m_kd; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            model_push(3'b001, 3);
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else begin
            m_code = b;
            m_kext = m_ext;
            if (b == 8'h29 && !m_ext) m_kd = !m_brk;
            model_push(m_brk ? 3'b010 : 3'b100, 4);
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    task automatic model_timeout();
        model_push(3'b001, TO + 4);
        m_brk = 0;
        m_ext = 0;
    endtask

    // Outputs are sampled on the falling system-clock edge.
    always @(negedge clk) begin
        if (resetN && (make || brake || frame_err)) begin
            check_val("make_brake_excl", {31'b0, make & brake}, 32'd0);
            if (exp_q.size() == 0) begin
                check_val("unexpected_pulse", {29'b0, make, brake, frame_err}, 32'd0);
            end else begin
                ev = exp_q.pop_front();
                check_val("event", {19'b0, make, brake, frame_err, key_code, key_ext, key_down},
                          {19'b0, ev.kind, ev.code, ev.ext, ev.kd});
                check_val("latency", cyc - last_fall, ev.lat);
            end
        end
    end

    task automatic ps2_fall(input logic d);
        @(negedge clk);
        ps2_data = d;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic p;
        p = (~^b) ^ bad_par;
        model_byte(b, !bad_par && !bad_stop);
        ps2_fall(1'b0);
        for (int i = 0; i < 8; i++) ps2_fall(b[i]);
        ps2_fall(p);
        ps2_fall(~bad_stop);
        ps2_data = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        ps2_fall(1'b0);
        for (int i = 0; i < nbits; i++) ps2_fall(b[i]);
        ps2_data = 1'b1;
    endtask

    task automatic check_levels(input string tag);
        check_val({tag, "_key_down"}, {31'b0, key_down}, {31'b0, m_kd});
        check_val({tag, "_key_code"}, {23'b0, key_code, key_ext}, {23'b0, m_code, m_kext});
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         sel;
        model_clear();
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_outputs", {19'b0, key_code, key_ext, make, brake, key_down, frame_err}, 32'd0);
        resetN = 1'b1;
        repeat (4) @(negedge clk);

        send_frame(8'h29, 0, 0);
        check_levels("make29");
        send_frame(8'hF0, 0, 0);
        send_frame(8'h29, 0, 0);
        check_levels("brk29");
        send_frame(8'hE0, 0, 0);
        send_frame(8'h29, 0, 0);
        check_levels("ext_make");
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h29, 0, 0);
        check_levels("ext_brk");
        send_frame(8'h1C, 1, 0);
        check_levels("bad_par");

        // Start bit sampled high: single error, receiver stays idle.
        model_push(3'b001, 3);
        ps2_fall(1'b1);
        repeat (6) @(negedge clk);
        send_frame(8'h1C, 0, 1);

        // Pending E0 survives a parity error.
        send_frame(8'hE0, 0, 0);
        send_frame(8'h1C, 1, 0);
        send_frame(8'h29, 0, 0);
        check_levels("ext_survive");

        // Pending E0 is dropped by a timeout.
        send_frame(8'hE0, 0, 0);
        model_timeout();
        send_partial(8'h29, 4);
        repeat (TO + 20) @(negedge clk);
        check_val("timeout_drained", exp_q.size(), 32'd0);
        send_frame(8'h29, 0, 0);
        check_levels("after_timeout");

        for (int i = 0; i < 3; i++) begin
            send_frame(8'h29, 0, 0);
            check_val("typematic_kd", {31'b0, key_down}, 32'd1);
        end

        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0, 1: b = 8'h29;
                2:    b = 8'hF0;
                3:    b = 8'hE0;
                4:    b = 8'h1C;
                default: b = 8'($urandom);
            endcase
            send_frame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0));
            check_levels("rand");
        end

        send_frame(8'h29, 0, 0);
        check_val("pre_reset_kd", {31'b0, key_down}, 32'd1);
        send_partial(8'h29, 3);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        check_val("midframe_reset",
                  {19'b0, key_code, key_ext, make, brake, key_down, frame_err}, 32'd0);
        model_clear();
        repeat (4) @(negedge clk);
        resetN = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h29, 0, 0);
        check_levels("post_reset");

        repeat (20) @(negedge clk);
        check_val("events_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
